// File: rtl/fsmc_buffer_bridge.sv
// FSMC async-SRAM slave exposing a block RAM through a DATA/INDEX/CTRL/STATUS window.
// Strobes are synchronised into clk; accesses take effect on the trailing (rising) strobe edge.
module fsmc_buffer_bridge #(
    parameter int DW   = 16,
    parameter int AW   = 9,
    parameter int SYNC = 3
) (
    input  logic          clk,
    input  logic          reset_l,
    input  logic          nce,
    input  logic          noe,
    input  logic          nwe,
    input  logic [1:0]    addr,
    inout  wire  [DW-1:0] data,
    output logic [AW-1:0] index,
    output logic          irq,
    output logic [3:0]    leds
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW-1:0] TOP = '1;

    logic [SYNC-1:0] oe_sync;
    logic [SYNC-1:0] we_sync;
    logic            oe_ns, oe_np;
    logic            we_ns, we_np;
    logic            rd_end, wr_end;

    logic [DW-1:0]   mem [DEPTH];
    logic [DW-1:0]   latch;
    logic            wrap, autoinc, ovf;

    logic [AW-1:0]   index_n;
    logic            wrap_n, autoinc_n, ovf_n;
    logic            mem_we, adv;
    logic [DW-1:0]   rdata;
    logic            drive;

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            oe_sync <= '1;
            we_sync <= '1;
        end else begin
            oe_sync <= {oe_sync[SYNC-2:0], noe};
            we_sync <= {we_sync[SYNC-2:0], nwe};
        end
    end

    assign oe_ns  = oe_sync[SYNC-2];
    assign oe_np  = oe_sync[SYNC-1];
    assign we_ns  = we_sync[SYNC-2];
    assign we_np  = we_sync[SYNC-1];
    assign rd_end = oe_ns & ~oe_np & ~nce;
    assign wr_end = we_ns & ~we_np & ~nce;

    // A write wins over a coincident read; a saturated DATA write is dropped entirely.
    always_comb begin
        index_n   = index;
        wrap_n    = wrap;
        autoinc_n = autoinc;
        ovf_n     = ovf;
        mem_we    = 1'b0;
        adv       = 1'b0;
        if (wr_end) begin
            case (addr)
                2'd0: begin
                    if (!(ovf && !wrap)) begin
                        mem_we = 1'b1;
                        adv    = 1'b1;
                    end
                end
                2'd1: index_n = data[AW-1:0];
                2'd2: {wrap_n, autoinc_n} = data[1:0];
                default: begin
                    if (data[0]) ovf_n = 1'b0;
                end
            endcase
        end else if (rd_end && addr == 2'd0) begin
            adv = 1'b1;
        end
        if (adv && autoinc) begin
            if (index != TOP) index_n = index + 1'b1;
            else if (wrap)    index_n = '0;
            else              ovf_n   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            index   <= '0;
            wrap    <= 1'b1;
            autoinc <= 1'b1;
            ovf     <= 1'b0;
        end else begin
            index   <= index_n;
            wrap    <= wrap_n;
            autoinc <= autoinc_n;
            ovf     <= ovf_n;
        end
    end

    // Memory contents survive reset; only the write strobe is gated.
    always_ff @(posedge clk) begin
        if (mem_we && reset_l) mem[index] <= data;
    end

    always_ff @(posedge clk) begin
        if (!reset_l) latch <= '0;
        else          latch <= mem[index];
    end

    always_comb begin
        rdata = '0;
        case (addr)
            2'd0:    rdata = latch;
            2'd1:    rdata[AW-1:0] = index;
            2'd2:    rdata[1:0] = {wrap, autoinc};
            default: rdata[0] = ovf;
        endcase
    end

    // nce and reset_l act directly so the bus frees without waiting for a clock.
    assign drive = reset_l & ~nce & ~oe_ns;
    assign data  = drive ? rdata : {DW{1'bz}};

    assign irq  = ovf;
    assign leds = index[3:0];

endmodule

// File: tb/tb_fsmc_buffer_bridge.sv
// Bench for fsmc_buffer_bridge: directed table, bus-release and reset corners,
// then randomized accesses against a register-level reference model.
module tb_fsmc_buffer_bridge;

    localparam int DW   = 16;
    localparam int AW   = 9;
    localparam int SYNC = 3;
    localparam int DEPTH = 1 << AW;
    localparam int TOPI = DEPTH - 1;

    logic          clk = 1'b0;
    logic          reset_l;
    logic          nce, noe, nwe;
    logic [1:0]    addr;
    wire  [DW-1:0] data;
    logic [AW-1:0] index;
    logic          irq;
    logic [3:0]    leds;

    logic          tb_oe;
    logic [DW-1:0] tb_dout;

    assign data = tb_oe ? tb_dout : {DW{1'bz}};

    always #5 clk = ~clk;

    fsmc_buffer_bridge #(.DW(DW), .AW(AW), .SYNC(SYNC)) dut (
        .clk(clk), .reset_l(reset_l), .nce(nce), .noe(noe), .nwe(nwe),
        .addr(addr), .data(data), .index(index), .irq(irq), .leds(leds)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: register window semantics only.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_vld [DEPTH];
    int            m_idx;
    bit            m_wrap, m_auto, m_ovf;

    function automatic void m_reset();
        m_idx = 0; m_wrap = 1; m_auto = 1; m_ovf = 0;
    endfunction

    function automatic void m_adv();
        if (!m_auto) return;
        if (m_idx < TOPI) m_idx = m_idx + 1;
        else if (m_wrap)  m_idx = 0;
        else              m_ovf = 1;
    endfunction

    function automatic void m_write(input int a, input logic [DW-1:0] v);
        case (a)
            0: if (!(m_ovf && !m_wrap)) begin
                m_mem[m_idx] = v;
                m_vld[m_idx] = 1;
                m_adv();
            end
            1: m_idx = int'(v) % DEPTH;
            2: begin m_wrap = v[1]; m_auto = v[0]; end
            default: if (v[0]) m_ovf = 0;
        endcase
    endfunction

    function automatic logic [DW-1:0] m_read(input int a, output bit known);
        logic [DW-1:0] r;
        known = 1;
        case (a)
            0: begin r = m_mem[m_idx]; known = m_vld[m_idx]; m_adv(); end
            1: r = DW'(m_idx);
            2: r = DW'({m_wrap, m_auto});
            default: r = DW'(m_ovf);
        endcase
        return r;
    endfunction

    task automatic bus_write(input logic [1:0] a, input logic [DW-1:0] v);
        nce = 0; addr = a; tb_oe = 1; tb_dout = v;
        @(negedge clk);
        nwe = 0;
        repeat (SYNC + 1) @(negedge clk);
        nwe = 1;
        repeat (SYNC + 1) @(negedge clk);
        nce = 1; tb_oe = 0;
        @(negedge clk);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [DW-1:0] v);
        nce = 0; addr = a; tb_oe = 0;
        @(negedge clk);
        noe = 0;
        repeat (SYNC + 1) @(negedge clk);
        v = data;
        noe = 1;
        repeat (SYNC + 1) @(negedge clk);
        nce = 1;
        @(negedge clk);
    endtask

    task automatic check_regs(input string tag, input int ei, input bit eirq);
        check({tag, " index"}, 32'(index), 32'(ei));
        check({tag, " irq"}, 32'(irq), 32'(eirq));
        check({tag, " leds"}, 32'(leds), 32'(ei % 16));
    endtask

    typedef struct {
        bit            wr;
        logic [1:0]    a;
        logic [DW-1:0] v;
        int            eidx;
        bit            eirq;
    } vec_t;

    vec_t vt[$];

    function automatic void add(input bit wr, input logic [1:0] a,
                                input logic [DW-1:0] v, input int ei,
                                input bit eq);
        vec_t e;
        e.wr = wr; e.a = a; e.v = v; e.eidx = ei; e.eirq = eq;
        vt.push_back(e);
    endfunction

    initial begin
        logic [DW-1:0] r, ev;
        bit known;

        reset_l = 0; nce = 1; noe = 1; nwe = 1; addr = 0;
        tb_oe = 0; tb_dout = '0;
        for (int i = 0; i < DEPTH; i++) m_vld[i] = 0;
        m_reset();
        repeat (3) @(negedge clk);
        reset_l = 1;
        @(negedge clk);
        check_regs("reset", 0, 0);
        bus_read(2, r); check("reset ctrl", 32'(r), 32'h3);
        bus_read(3, r); check("reset status", 32'(r), 32'h0);

        // {wr, addr, data or expected read, expected index, expected irq}
        add(1, 1, 16'd5,    5,    0);
        add(1, 0, 16'hA001, 6,    0);
        add(1, 0, 16'hA002, 7,    0);
        add(1, 0, 16'hA003, 8,    0);
        add(0, 1, 16'd8,    8,    0);
        add(1, 1, 16'd5,    5,    0);
        add(0, 1, 16'd5,    5,    0);
        add(0, 0, 16'hA001, 6,    0);
        add(0, 0, 16'hA002, 7,    0);
        add(0, 0, 16'hA003, 8,    0);
        add(1, 1, 16'(TOPI), TOPI, 0);
        add(1, 0, 16'h1234, 0,    0);
        add(1, 1, 16'(TOPI), TOPI, 0);
        add(0, 0, 16'h1234, 0,    0);
        add(0, 2, 16'h3,    0,    0);
        add(1, 2, 16'h1,    0,    0);
        add(1, 1, 16'(TOPI), TOPI, 0);
        add(1, 0, 16'h5555, TOPI, 1);
        add(1, 0, 16'h6666, TOPI, 1);
        add(0, 0, 16'h5555, TOPI, 1);
        add(0, 3, 16'h1,    TOPI, 1);
        add(1, 3, 16'h1,    TOPI, 0);
        add(0, 3, 16'h0,    TOPI, 0);
        add(1, 2, 16'h2,    TOPI, 0);
        add(1, 1, 16'd3,    3,    0);
        add(1, 0, 16'h1111, 3,    0);
        add(1, 0, 16'h2222, 3,    0);
        add(1, 0, 16'h3333, 3,    0);
        add(1, 0, 16'h4444, 3,    0);
        add(0, 0, 16'h4444, 3,    0);
        add(0, 2, 16'h2,    3,    0);
        add(0, 1, 16'd3,    3,    0);
        add(1, 2, 16'h0,    3,    0);

        foreach (vt[i]) begin
            if (vt[i].wr) begin
                bus_write(vt[i].a, vt[i].v);
                m_write(int'(vt[i].a), vt[i].v);
            end else begin
                bus_read(vt[i].a, r);
                ev = m_read(int'(vt[i].a), known);
                check($sformatf("vec%0d rd", i), 32'(r), 32'(vt[i].v));
            end
            check_regs($sformatf("vec%0d", i), vt[i].eidx, vt[i].eirq);
        end

        // Bus must be released while deselected or while noe is high.
        addr = 1; nce = 0; noe = 1; tb_oe = 1; tb_dout = '0;
        repeat (2) @(negedge clk);
        check("bus noe high", 32'(data), 32'h0);
        nce = 1; noe = 0;
        repeat (SYNC + 1) @(negedge clk);
        check("bus nce high", 32'(data), 32'h0);
        noe = 1;
        repeat (SYNC + 1) @(negedge clk);
        tb_oe = 0;
        check_regs("no side effect", 3, 0);

        // Reset asserted in the middle of an INDEX read.
        nce = 0; addr = 1;
        @(negedge clk);
        noe = 0;
        repeat (SYNC + 1) @(negedge clk);
        check("midread data", 32'(data), 32'h3);
        reset_l = 0; tb_oe = 1; tb_dout = '0;
        #1 check("reset release now", 32'(data), 32'h0);
        @(negedge clk);
        check("reset release clk", 32'(data), 32'h0);
        noe = 1; nce = 1;
        repeat (SYNC + 1) @(negedge clk);
        tb_oe = 0; reset_l = 1;
        m_reset();
        @(negedge clk);
        check_regs("post reset", 0, 0);
        bus_read(2, r); check("post reset ctrl", 32'(r), 32'h3);
        bus_write(1, 16'd5); m_write(1, 16'd5);
        bus_read(0, r); ev = m_read(0, known);
        check("mem kept", 32'(r), 32'hA001);
        check_regs("mem kept", 6, 0);

        // Fill memory so every later DATA read has a known value.
        bus_write(2, 16'h3); m_write(2, 16'h3);
        bus_write(1, 16'd0); m_write(1, 16'd0);
        for (int i = 0; i < DEPTH; i++) begin
            r = 16'($urandom);
            bus_write(0, r); m_write(0, r);
        end
        check_regs("fill", m_idx, m_ovf);

        for (int n = 0; n < 300; n++) begin
            int sel;
            logic [1:0] a;
            bit wr;
            sel = $urandom_range(0, 11);
            wr = 1; a = 0; r = 16'($urandom);
            if (sel < 4) begin
                a = 0;
            end else if (sel < 7) begin
                wr = 0; a = 0;
            end else if (sel == 7) begin
                a = 1;
                if ($urandom_range(0, 1) == 1)
                    r = 16'(TOPI - $urandom_range(0, 2));
            end else if (sel == 8) begin
                a = 2;
            end else if (sel == 9) begin
                a = 3;
            end else begin
                wr = 0; a = 2'($urandom_range(1, 3));
            end
            if (wr) begin
                bus_write(a, r);
                m_write(int'(a), r);
            end else begin
                logic [DW-1:0] got;
                bus_read(a, got);
                ev = m_read(int'(a), known);
                if (known)
                    check($sformatf("rnd%0d rd a%0d", n, a), 32'(got), 32'(ev));
            end
            check_regs($sformatf("rnd%0d", n), m_idx, m_ovf);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
